fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage of the 5-stage MIPS pipeline. Generates the PC stream and issues reads to a synchronous, 1-cycle-latency instruction memory. Buffers returned words in a small FIFO and presents them to decode through a valid/ready handshake, exposing the opcode and funct fields that the control decoder consumes. Branch, jump and jr resolution redirect the PC and flush everything fetched down the wrong path.

## Interface
Parameters:
- `DEPTH`, 2 — FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0000_0000 — first fetch address after reset.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `imem_req` out 1 — read request this cycle.
- `imem_addr` out 32 — byte address of the read; the low 2 bits are always 0.
- `imem_rdata` in 32 — read data, valid in the cycle after `imem_req`.
- `redirect` in 1 — control-flow change resolved downstream.
- `redirect_pc` in 32 — target address; the low 2 bits are ignored (forced to 0).
- `if_valid` out 1 — head instruction available.
- `id_ready` in 1 — decode accepts the head this cycle.
- `if_instr` out 32 — head instruction word.
- `if_opcode` out 6 — `if_instr[31:26]`.
- `if_funct` out 6 — `if_instr[5:0]`.
- `if_pc` out 32 — address of the head instruction.
- `if_pc_plus4` out 32 — `if_pc + 4`, modulo 2^32.

## Operation
- **State:** `pc_q` (next fetch address), `inflight` flag with its captured address, FIFO of {instr, pc}, occupancy `count`.
- **Issue:** `imem_req = !redirect && (count + inflight − pop) < DEPTH`, where `pop = if_valid && id_ready`. `imem_addr = pc_q`.
  - On issue: `pc_q <= pc_q + 4`, wrapping from 32'hFFFF_FFFC to 0.
  - On issue: `inflight <= 1` and the address is latched; otherwise `inflight <= 0`.
- **Response:** when `inflight` is set and there is no redirect this cycle, push {`imem_rdata`, latched address}. The credit rule above guarantees the FIFO is never full on a push.
- **Handshake:**
  - Transfer occurs when `if_valid && id_ready`.
  - While `if_valid && !id_ready`, all `if_*` outputs hold stable.
  - `if_valid` never drops without a transfer or a redirect.
- **Redirect (cycle R):**
  - FIFO is cleared and `count <= 0`.
  - A response arriving in R is discarded, and `inflight <= 0`.
  - `pc_q <= {redirect_pc[31:2], 2'b00}`, and no request is issued in R.
- **Simultaneous redirect and transfer:** redirect wins the flush; the transfer in R still counts as consumed.
- **Simultaneous push and pop:** `count` is unchanged, and head/tail advance.
- **Empty FIFO:** `if_valid = 0`. The `if_*` data outputs hold their last value (don't-care).
- **Reset (asynchronous, any time, including mid-request):** a response pending when `rst_n` falls is lost. Values while reset is asserted:
  - `pc_q = RESET_PC`
  - `count = 0`, `inflight = 0`
  - `imem_req = 0`, `imem_addr = RESET_PC`
  - `if_valid = 0`, `if_instr = 0`, `if_opcode = 0`, `if_funct = 0`
  - `if_pc = 0`, `if_pc_plus4 = 4`

## Timing
- **Fetch latency:** request in cycle N → data in N+1 → written to the FIFO at the end of N+1 → `if_valid` in N+2. There is no bypass.
- **First instruction after `rst_n` rises:** request in cycle 0, `if_valid` in cycle 2.
- **Redirect penalty:** redirect in R → request to the target in R+1 → `if_valid` in R+3.
- **Throughput:** with `DEPTH=2` and `id_ready` held high, one instruction per cycle in steady state.
- **Back-pressure:** when `id_ready` drops, at most `DEPTH` instructions are outstanding and `imem_req` deasserts. Issue resumes in the same cycle that a pop frees a credit.
- **Output timing:** all outputs are registered or derived from the FIFO head, except `imem_req`, which depends combinationally on `redirect` and `id_ready`.

## Structure
- **Shared package `mips_pkg`:**
  - Field-position constants: `OPCODE_MSB/LSB = 31/26`, `FUNCT_MSB/LSB = 5/0`.
  - `INSTR_W = 32`, `PC_STEP = 4`.
  - Typedef for the {instr, pc} FIFO entry.
- **Sub-module `fetch_fifo`:**
  - Parameterized synchronous FIFO with push, pop, flush, count and head data.
  - `flush` has priority over push.
  - Reset uses the same asynchronous active-low `rst_n`.
- **Top level** holds the PC, the inflight tracking and the credit logic.

## Test plan
- **Reset release, `id_ready=1`, imem returns `addr^32'hA5A5_0000`:**
  - `imem_addr` = 0, 4, 8, … in cycles 0, 1, 2.
  - `if_valid` rises in cycle 2 with `if_pc=0`, then one transfer per cycle.
  - `if_pc_plus4 = if_pc + 4`.
- **Stall:** `id_ready=0` for 5 cycles from cycle 3.
  - `imem_req` deasserts once 2 credits are consumed.
  - `if_instr`/`if_pc` are stable throughout.
  - On release, PCs continue without a gap or duplicate.
- **Redirect during an inflight request:** `redirect=1`, `redirect_pc=32'h0000_0103` in cycle R.
  - `imem_req=0` in R.
  - `imem_addr=32'h0000_0100` in R+1.
  - First `if_pc` after R is 32'h100, in R+3; no old PC appears after R.
- **Redirect with a full FIFO and `id_ready=1` in the same cycle:**
  - Flush occurs and `count=0` in R+1.
  - Next delivered PC is the target.
- **Wrap-around:** `redirect_pc=32'hFFFF_FFF8`.
  - Delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - `if_pc_plus4` at FFFF_FFFC is 0.
- **Async reset mid-stream:** assert `rst_n=0` between clock edges with 2 entries buffered.
  - Outputs go to their reset values immediately.
  - After release, fetch restarts at `RESET_PC` with no stale instruction.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_W       = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    // One buffered fetch: the instruction word and the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: none internally; the caller never pushes when full (credit rule) and never pops when empty.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fq_entry_t        push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fq_entry_t        head_dat
);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // Storage write; cleared on reset so the head reads as all-zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointer and occupancy update; flush beats both push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: PC generation, 1-cycle imem reads, buffered delivery to decode.
// Latency: request in N, data in N+1, if_valid in N+2; redirect in R gives target at decode in R+3.
// Backpressure: id_ready low holds the head; issue stops once DEPTH fetches are buffered or in flight.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [5:0]  if_opcode,
    output logic [5:0]  if_funct,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0]      pc_q, pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credits_used;
    logic             pop;
    logic             push;
    logic             issue;
    fq_entry_t        head;
    fq_entry_t        push_entry;

    // A slot is reserved for every buffered entry and every outstanding read; a pop frees one this cycle.
    assign pop          = if_valid && id_ready;
    assign credits_used = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign issue        = rst_n && !redirect && (credits_used < (CNT_W + 1)'(DEPTH));
    assign push         = inflight_q && !redirect;
    assign push_entry   = '{instr: imem_rdata, pc: inflight_pc_q};

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    assign if_valid    = (count != '0);
    assign if_instr    = head.instr;
    assign if_opcode   = head.instr[OPCODE_MSB:OPCODE_LSB];
    assign if_funct    = head.instr[FUNCT_MSB:FUNCT_LSB];
    assign if_pc       = head.pc;
    assign if_pc_plus4 = head.pc + PC_STEP;

    // Next fetch address and in-flight tracking; a redirect cancels the outstanding read.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d          = pc_q + PC_STEP;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= START_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= START_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect),
        .count    (count),
        .head_dat (head)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [5:0]  if_funct;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: delivered-PC queue, one optional outstanding read, next fetch address.
    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_npc;

    // Memory model: the read observed at the last edge.
    logic        req_seen;
    logic [31:0] addr_seen;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_funct    (if_funct),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(string when);
        check_val({when, "/imem_req"},    32'(imem_req),    32'd0);
        check_val({when, "/imem_addr"},   imem_addr,        RESET_PC);
        check_val({when, "/if_valid"},    32'(if_valid),    32'd0);
        check_val({when, "/if_instr"},    if_instr,         32'd0);
        check_val({when, "/if_opcode"},   32'(if_opcode),   32'd0);
        check_val({when, "/if_funct"},    32'(if_funct),    32'd0);
        check_val({when, "/if_pc"},       if_pc,            32'd0);
        check_val({when, "/if_pc_plus4"}, if_pc_plus4,      32'd4);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_pend_pc = 32'd0;
        m_npc = RESET_PC;
    endtask

    // One clock cycle: entered 1 time unit after a rising edge; drives inputs, checks, advances.
    task automatic cycle(bit redir, logic [31:0] rpc, bit rdy);
        bit          exp_vld;
        bit          pop;
        bit          exp_req;
        int          occ;
        logic [31:0] hp;
        logic [31:0] iw;
        logic [31:0] nxt;
        redirect    = redir;
        redirect_pc = rpc;
        id_ready    = rdy;
        #2;
        exp_vld = (mq.size() > 0);
        pop     = exp_vld && rdy;
        occ     = mq.size() + int'(m_pend) - int'(pop);
        exp_req = !redir && (occ < DEPTH);
        check_val("imem_req",  32'(imem_req), 32'(exp_req));
        check_val("imem_addr", imem_addr,     m_npc);
        check_val("if_valid",  32'(if_valid), 32'(exp_vld));
        if (exp_vld) begin
            hp  = mq[0];
            iw  = mem_word(hp);
            nxt = hp + 32'd4;
            check_val("if_instr",    if_instr,        iw);
            check_val("if_pc",       if_pc,           hp);
            check_val("if_opcode",   32'(if_opcode),  32'(iw[31:26]));
            check_val("if_funct",    32'(if_funct),   32'(iw[5:0]));
            check_val("if_pc_plus4", if_pc_plus4,     nxt);
        end
        req_seen  = imem_req;
        addr_seen = imem_addr;
        if (redir) begin
            mq.delete();
            m_pend = 1'b0;
            m_npc  = {rpc[31:2], 2'b00};
        end else begin
            if (pop) begin
                void'(mq.pop_front());
            end
            if (m_pend) begin
                mq.push_back(m_pend_pc);
            end
            if (exp_req) begin
                m_pend    = 1'b1;
                m_pend_pc = m_npc;
                m_npc     = m_npc + 32'd4;
            end else begin
                m_pend = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        imem_rdata = req_seen ? mem_word(addr_seen) : 32'hDEAD_BEEF;
    endtask

    task automatic random_run(int n);
        logic [31:0] rpc;
        bit          rd;
        bit          rdy;
        for (int k = 0; k < n; k++) begin
            rd  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 3) == 0) begin
                rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            end else begin
                rpc = $urandom;
            end
            cycle(rd, rpc, rdy);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        id_ready    = 1'b1;
        imem_rdata  = 32'd0;
        req_seen    = 1'b0;
        addr_seen   = 32'd0;
        model_reset();
        #12;
        check_reset_outputs("reset");

        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Cold start, then a stall from cycle 3, then release.
        repeat (3) cycle(1'b0, 32'd0, 1'b1);
        repeat (5) cycle(1'b0, 32'd0, 1'b0);
        repeat (4) cycle(1'b0, 32'd0, 1'b1);

        // Redirect while a read is in flight; unaligned target.
        cycle(1'b1, 32'h0000_0103, 1'b1);
        repeat (5) cycle(1'b0, 32'd0, 1'b1);

        // Fill the FIFO, then redirect together with a transfer.
        repeat (4) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h0000_0200, 1'b1);
        repeat (5) cycle(1'b0, 32'd0, 1'b1);

        // Address wrap-around.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) cycle(1'b0, 32'd0, 1'b1);

        random_run(3000);

        // Asynchronous reset between edges with two entries buffered.
        repeat (4) cycle(1'b0, 32'd0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (10) cycle(1'b0, 32'd0, 1'b1);
        random_run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
